// File: rtl/led_bar_arbiter.sv
// led_bar_arbiter: round-robin owner of the 16-LED bar with min/max hold in display ticks
//   clk, reset_n (async, active low)
//   req[NUM_REQ]        per-requester request level
//   pattern[16*NUM_REQ] requester i drives bits [16*i+15:16*i]
//   flick               async button, rising edge skips the current owner
//   Y, grant            registered LED drive and one-hot grant
//   owner, busy         current owner index (valid while busy), GRANT state flag
//   tick                one-cycle display-tick strobe
//   LED_ARB_PRIO0_EN    optional: requester 0 wins IDLE and pre-empts others on a tick
module led_bar_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DIV      = 25000000,
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  pattern,
  input  logic                   flick,
  output logic [15:0]            Y,
  output logic [NUM_REQ-1:0]     grant,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic                   tick
);
  localparam int CW = $clog2(DIV);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0] y_q, y_d, own_pat;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [2:0] owner_q, owner_d, rr_q, rr_d, pick;
  logic [2:0] sync_q, sync_d;
  logic flick_rise, own_req, others, exit_now;
  assign tick = cnt_q == CW'(DIV - 1);
  // sync_q[1] is the synchronised button, sync_q[2] its previous value
  assign flick_rise = sync_q[1] & ~sync_q[2];
  // grant_q is one-hot on the owner while in GRANT, so it doubles as the owner mask
  assign own_req = |(req & grant_q);
  assign others = |(req & ~grant_q);
  assign Y = y_q;
  assign grant = grant_q;
  assign owner = owner_q;
  assign busy = state_q == GRANT;
  always_comb begin
    own_pat = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) own_pat = pattern[16*i +: 16];
  end
  // first set request after rr_ptr: iterate farthest first so the nearest wins
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      for (int i = 0; i < NUM_REQ; i++)
        if (req[i] && i == (int'(rr_q) + k) % NUM_REQ) pick = 3'(i);
`ifdef LED_ARB_PRIO0_EN
    if (req[0]) pick = '0;
`endif
  end
  always_comb begin
`ifdef LED_ARB_PRIO0_EN
    exit_now = (!own_req && hold_q >= HW'(MIN_HOLD))
            || (hold_q == HW'(MAX_HOLD) && others && !grant_q[0])
            || (flick_rise && others)
            || (tick && req[0] && !grant_q[0]);
`else
    exit_now = (!own_req && hold_q >= HW'(MIN_HOLD))
            || (hold_q == HW'(MAX_HOLD) && others)
            || (flick_rise && others);
`endif
  end
  always_comb begin
    state_d = state_q;
    y_d = y_q;
    grant_d = grant_q;
    owner_d = owner_q;
    hold_d = hold_q;
    rr_d = rr_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    sync_d = {sync_q[1:0], flick};
    case (state_q)
      IDLE: begin
        y_d = '0;
        grant_d = '0;
        if (|req) begin
          state_d = GRANT;
          owner_d = pick;
          hold_d = '0;
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = pick == 3'(i);
        end
      end
      GRANT: begin
        if (exit_now) begin
          state_d = SWITCH;
          y_d = '0;
          grant_d = '0;
        end else begin
          y_d = own_req ? own_pat : y_q;
          hold_d = (tick && hold_q != HW'(MAX_HOLD)) ? hold_q + 1'b1 : hold_q;
        end
      end
      SWITCH: begin
        state_d = IDLE;
        rr_d = owner_q;
        y_d = '0;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hold_q <= '0;
      y_q <= '0;
      grant_q <= '0;
      owner_q <= '0;
      rr_q <= 3'(NUM_REQ - 1);
      sync_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      y_q <= y_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      sync_q <= sync_d;
    end
  end
endmodule

// File: tb/tb_led_bar_arbiter.sv
// tb_led_bar_arbiter: scoreboard bench for led_bar_arbiter against a tick/round-robin reference model
module tb_led_bar_arbiter;
  localparam int N = 4, DIV = 4, MINH = 2, MAXH = 8;
  typedef logic [24:0] obs_t;
  logic clk = 0, reset_n = 0, flick = 0;
  logic [N-1:0] req = '0;
  logic [16*N-1:0] pattern = '0;
  logic [15:0] Y;
  logic [N-1:0] grant;
  logic [2:0] owner;
  logic busy, tick;
  int checks = 0, fails = 0;
  obs_t expq[$];
  obs_t e, a;
  led_bar_arbiter #(.NUM_REQ(N), .DIV(DIV), .MIN_HOLD(MINH), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .pattern(pattern), .flick(flick),
    .Y(Y), .grant(grant), .owner(owner), .busy(busy), .tick(tick)
  );
  always #5 clk = ~clk;
  function automatic obs_t pack(logic [15:0] y, logic [N-1:0] g, logic [2:0] o, logic b, logic t);
    return {y, g, b ? o : 3'd0, b, t};
  endfunction
  int m_phase, m_own, m_hold, m_rr, m_presc, pick;
  logic [15:0] m_y;
  bit f0, f1, f2, tk, rise, oth, mine;
  task automatic model_reset();
    m_phase = 0; m_own = 0; m_hold = 0; m_rr = N - 1; m_presc = 0; m_y = '0;
    f0 = 0; f1 = 0; f2 = 0;
  endtask
  always @(negedge reset_n) model_reset();
  always @(posedge clk) begin
    if (!reset_n) begin
      model_reset();
      expq.push_back(pack('0, '0, '0, 0, 0));
    end else begin
      tk = m_presc == DIV - 1;
      rise = f1 && !f2;
      if (m_phase == 0) begin
        if (req != 0) begin
          pick = -1;
          for (int k = 1; k <= N; k++)
            if (pick < 0 && req[(m_rr + k) % N]) pick = (m_rr + k) % N;
          m_own = pick; m_hold = 0; m_phase = 1; m_y = '0;
        end
      end else if (m_phase == 1) begin
        mine = req[m_own];
        oth = (req & ~(4'(1) << m_own)) != 0;
        if ((!mine && m_hold >= MINH) || (m_hold == MAXH && oth) || (rise && oth)) begin
          m_phase = 2; m_y = '0;
        end else begin
          if (mine) m_y = pattern[16*m_own +: 16];
          if (tk && m_hold < MAXH) m_hold++;
        end
      end else begin
        m_rr = m_own; m_phase = 0;
      end
      f2 = f1; f1 = f0; f0 = flick;
      m_presc = (m_presc + 1) % DIV;
      expq.push_back(pack(m_y, m_phase == 1 ? 4'(1) << m_own : 4'd0, 3'(m_own), m_phase == 1, m_presc == DIV - 1));
    end
  end
  always @(negedge clk) begin
    checks++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_underflow t=%0t no expected entry", $time);
    end else begin
      e = expq.pop_front();
      a = pack(Y, grant, owner, busy, tick);
      if (a !== e) begin
        fails++;
        if (fails <= 20)
          $display("FAIL cycle_obs t=%0t got Y=%h grant=%b owner=%0d busy=%b tick=%b want Y=%h grant=%b owner=%0d busy=%b tick=%b",
                   $time, a[24:9], a[8:5], a[4:2], a[1], a[0], e[24:9], e[8:5], e[4:2], e[1], e[0]);
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_busy", {31'd0, busy}, 32'd1);
  endtask
  task automatic flick_pulse(int w);
    #2 flick = 1;
    cyc(w);
    #2 flick = 0;
  endtask
  initial begin
    cyc(3);
    reset_n = 1;
    cyc(40);
    pattern[31:16] = 16'h7FFF;
    req = 4'b0010;
    wait_busy();
    cyc(3 * DIV);
    req = '0;
    cyc(10);
    pattern = {16'hF000, 16'h0F00, 16'h00F0, 16'h000F};
    req = 4'b1011;
    cyc(4 * (MAXH + 1) * DIV + 40);
    req = '0;
    cyc(10);
    pattern[31:16] = 16'h003F;
    req = 4'b0010;
    wait_busy();
    cyc(2);
    req = '0;
    cyc(20);
    req = 4'b0001;
    wait_busy();
    cyc(DIV);
    req = 4'b0101;
    flick_pulse(3);
    cyc(20);
    req = 4'b0001;
    wait_busy();
    cyc(4);
    flick_pulse(3);
    cyc(20);
    req = '0;
    cyc(8);
    req = 4'b1011;
    wait_busy();
    cyc(6);
    #2 reset_n = 0;
    #1;
    chk("async_rst_Y", {16'd0, Y}, 32'd0);
    chk("async_rst_grant", {28'd0, grant}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    cyc(2);
    #2 reset_n = 1;
    wait_busy();
    chk("restart_owner", {29'd0, owner}, 32'd0);
    cyc(20);
    req = '0;
    cyc(10);
    repeat (150) begin
      req = 4'($urandom);
      pattern = {$urandom, $urandom};
      flick = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 30));
    end
    flick = 0;
    req = '0;
    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
